instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream neighbour of the single-cycle datapath in the 16-bit TSC CPU.
- Owns the PC and fetches each instruction over the shared memory read handshake (readM/inputReady).
- Holds the fetched instruction stable for the datapath while that instruction executes.
- Chooses the next PC from the branch/jump controls and datapath results (b_cond, immediate, cpu_alu_output); drives pc_value, the link address used by PctoReg.

Parameters:
- WORD_WIDTH, 16, width of PC, address, instruction and immediate.
- RESET_PC, 16'h0000, PC value loaded at reset.
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- readM  output  1  instruction read request to memory
- i_address  output  WORD_WIDTH  fetch address (= PC)
- i_data  input  WORD_WIDTH  memory read data
- inputReady  input  1  memory read-data-valid strobe
- instruction  output  WORD_WIDTH  latched instruction to datapath/control
- instr_valid  output  1  instruction is in execute phase
- pc_value  output  WORD_WIDTH  PC+1 (link value for JAL/JALR)
- branch  input  1  current instruction is a conditional branch
- b_cond  input  1  branch condition from datapath ALU
- jal  input  1  current instruction is JAL
- jalr  input  1  current instruction is JALR
- immediate  input  WORD_WIDTH  sign-extended offset from datapath
- cpu_alu_output  input  WORD_WIDTH  JALR target (rs via ALU)
- exec_stall  input  1  datapath data-memory access still pending
- halt  input  1  current instruction is HLT
- is_halted  output  1  CPU halted
- num_inst  output  CNT_WIDTH  retired instruction count

Behaviour:
- Reset (async, reset_n=0): PC=RESET_PC, state=S_FETCH, instruction=16'h0000, readM=0, instr_valid=0, is_halted=0, num_inst=0. readM falls immediately even mid-fetch; an inputReady arriving during reset is discarded.
- readM is registered. It rises on the first clk edge after reset release or after leaving S_EXEC.
- S_FETCH:
  - readM=1, i_address=PC.
  - On an edge with inputReady=1: instruction<=i_data, readM<=0, go to S_EXEC.
  - Without inputReady: stay in S_FETCH; no timeout.
- S_EXEC:
  - instr_valid=1; instruction and PC held.
  - exec_stall=1: stay in S_EXEC.
  - Otherwise, on the edge: num_inst+=1.
    - halt=1: PC held, go to S_HALT.
    - halt=0: PC<=next_pc, go to S_FETCH.
  - The minimum instruction period is therefore 2 cycles, plus memory wait and stall cycles.
- S_HALT:
  - readM=0, instr_valid=0, is_halted=1.
  - Exited only by reset.
- next_pc priority (highest first):
  - jalr: cpu_alu_output
  - jal: {PC[15:12], instruction[11:0]}
  - branch&b_cond: PC+1+immediate
  - otherwise: PC+1
- Arithmetic:
  - All PC arithmetic is modulo 2^WORD_WIDTH; 16'hFFFF+1 wraps to 16'h0000.
  - pc_value is combinational PC+1 with the same wrap.
- inputReady while readM=0 (S_EXEC/S_HALT) is ignored; instruction is not overwritten.
- Simultaneous jal and branch asserted: jal wins (decoder fault tolerated, not flagged).
- num_inst wraps silently at 2^CNT_WIDTH.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: in S_FETCH, when inputReady=1 the instruction output is driven combinationally from i_data in that same cycle, so decode overlaps the fetch. The registered copy is used from S_EXEC on. State timing is unchanged.
- Undefined: instruction is purely registered, as described above.

Test Plan:
- Reset release, memory returns 16'h6001 one cycle after readM -> i_address=0000, then instruction=6001, instr_valid=1 for one cycle, next fetch address 0001, num_inst=1.
- Branch at PC=0010 with immediate=FFFC, b_cond=1 -> next i_address=000D; same with b_cond=0 -> 0011.
- JAL instruction 16'h9123 at PC=4005 -> pc_value=4006 during execute, next i_address=4123. JALR with cpu_alu_output=0200 and jal also high -> next address 0200.
- exec_stall held 3 cycles in execute -> instr_valid high 4 cycles, PC and num_inst unchanged until stall drops, then a single increment.
- PC=FFFF sequential instruction -> next i_address=0000. Stray inputReady pulse during execute -> instruction unchanged.
- halt in execute -> is_halted=1, readM stays 0 for 20 cycles, num_inst incremented once. reset_n pulled low mid-fetch -> readM=0 immediately, restart at RESET_PC, num_inst=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and instruction fetcher for the 16-bit TSC CPU; optional FETCH_BYPASS_EN forwards i_data to decode during the fetch cycle.
module instr_fetch_unit #(
  parameter int WORD_WIDTH = 16,
  parameter logic [WORD_WIDTH-1:0] RESET_PC = '0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  readM,
  output logic [WORD_WIDTH-1:0] i_address,
  input  logic [WORD_WIDTH-1:0] i_data,
  input  logic                  inputReady,
  output logic [WORD_WIDTH-1:0] instruction,
  output logic                  instr_valid,
  output logic [WORD_WIDTH-1:0] pc_value,
  input  logic                  branch,
  input  logic                  b_cond,
  input  logic                  jal,
  input  logic                  jalr,
  input  logic [WORD_WIDTH-1:0] immediate,
  input  logic [WORD_WIDTH-1:0] cpu_alu_output,
  input  logic                  exec_stall,
  input  logic                  halt,
  output logic                  is_halted,
  output logic [CNT_WIDTH-1:0]  num_inst
);
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_e;
  state_e state_q, state_d;
  logic [WORD_WIDTH-1:0] pc_q, pc_d, instr_q, instr_d, pc_inc, next_pc;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic readM_q, readM_d, accept, retire;
  // read data only counts once the registered request is actually visible to memory
  assign accept = (state_q == S_FETCH) && readM_q && inputReady;
  assign retire = (state_q == S_EXEC) && !exec_stall;
  assign pc_inc = pc_q + WORD_WIDTH'(1);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == S_FETCH) ? (accept ? S_EXEC : S_FETCH) :
              (state_q == S_EXEC)  ? (exec_stall ? S_EXEC : halt ? S_HALT : S_FETCH) :
              S_HALT;
  end
  always_comb begin
    next_pc = jalr ? cpu_alu_output :
              jal ? {pc_q[WORD_WIDTH-1:12], instr_q[11:0]} :
              (branch && b_cond) ? pc_inc + immediate : pc_inc;
    pc_d    = (retire && !halt) ? next_pc : pc_q;
    instr_d = accept ? i_data : instr_q;
    cnt_d   = cnt_q + CNT_WIDTH'(retire);
    readM_d = (state_d == S_FETCH);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      cnt_q   <= '0;
      readM_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      readM_q <= readM_d;
    end
  end
  always_comb begin
    readM       = readM_q;
    i_address   = pc_q;
    instr_valid = (state_q == S_EXEC);
    is_halted   = (state_q == S_HALT);
    pc_value    = pc_inc;
    num_inst    = cnt_q;
`ifdef FETCH_BYPASS_EN
    instruction = accept ? i_data : instr_q;
`else
    instruction = instr_q;
`endif
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed plus randomized fetch/execute sequences checked against a PC/count reference model.
module tb_instr_fetch_unit;
  logic clk = 0, reset_n = 0;
  logic readM, inputReady = 0, instr_valid, is_halted;
  logic [15:0] i_address, i_data = '0, instruction, pc_value, immediate = '0, cpu_alu_output = '0;
  logic branch = 0, b_cond = 0, jal = 0, jalr = 0, exec_stall = 0, halt = 0;
  logic [15:0] num_inst;
  int tests = 0, fails = 0;
  logic [15:0] m_pc, m_cnt, m_instr;

  instr_fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .readM(readM), .i_address(i_address), .i_data(i_data),
    .inputReady(inputReady), .instruction(instruction), .instr_valid(instr_valid),
    .pc_value(pc_value), .branch(branch), .b_cond(b_cond), .jal(jal), .jalr(jalr),
    .immediate(immediate), .cpu_alu_output(cpu_alu_output), .exec_stall(exec_stall),
    .halt(halt), .is_halted(is_halted), .num_inst(num_inst)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] data, input int waits);
    int n = 0;
    while (readM !== 1'b1 && n < 5) begin tick; n++; end
    chk("fetch_req", readM, 1);
    chk("fetch_addr", i_address, m_pc);
    for (int k = 0; k < waits; k++) begin
      tick;
      chk("wait_readM", readM, 1);
      chk("wait_valid", instr_valid, 0);
    end
    i_data = data;
    inputReady = 1;
    #1;
`ifdef FETCH_BYPASS_EN
    chk("bypass_instr", instruction, data);
`else
    chk("fetch_instr_hold", instruction, m_instr);
`endif
    tick;
    inputReady = 0;
    i_data = $urandom;
    m_instr = data;
    chk("exec_valid", instr_valid, 1);
    chk("exec_instr", instruction, data);
    chk("exec_readM", readM, 0);
  endtask

  task automatic execute(input logic br, bc, jl, jr, input logic [15:0] imm, alu,
                         input logic hlt, input int stalls, input logic stray);
    logic [15:0] nxt;
    branch = br; b_cond = bc; jal = jl; jalr = jr; immediate = imm; cpu_alu_output = alu; halt = hlt;
    for (int k = 0; k < stalls; k++) begin
      exec_stall = 1;
      if (stray && k == 0) begin inputReady = 1; i_data = ~m_instr; end
      tick;
      inputReady = 0;
      chk("stall_valid", instr_valid, 1);
      chk("stall_cnt", num_inst, m_cnt);
      chk("stall_pc", i_address, m_pc);
      chk("stall_instr", instruction, m_instr);
    end
    exec_stall = 0;
    #1;
    chk("pc_value", pc_value, 16'(m_pc + 16'd1));
    chk("last_valid", instr_valid, 1);
    if (jr) nxt = alu;
    else if (jl) nxt = {m_pc[15:12], m_instr[11:0]};
    else if (br && bc) nxt = m_pc + 16'd1 + imm;
    else nxt = m_pc + 16'd1;
    tick;
    m_cnt++;
    if (!hlt) m_pc = nxt;
    branch = 0; b_cond = 0; jal = 0; jalr = 0; halt = 0;
    chk("retire_cnt", num_inst, m_cnt);
    chk("retire_pc", i_address, m_pc);
    chk("retire_halted", is_halted, hlt);
    chk("retire_readM", readM, !hlt);
  endtask

  task automatic jump_to(input logic [15:0] target);
    fetch(16'($urandom), 0);
    execute(0, 0, 0, 1, 16'h0, target, 0, 0, 0);
  endtask

  initial begin
    m_pc = 16'h0000; m_cnt = 0; m_instr = 16'h0000;
    tick; tick;
    chk("rst_readM", readM, 0);
    chk("rst_addr", i_address, 16'h0000);
    chk("rst_instr", instruction, 16'h0000);
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", is_halted, 0);
    chk("rst_cnt", num_inst, 0);
    reset_n = 1;
    tick;
    chk("first_readM", readM, 1);
    tick;
    fetch(16'h6001, 0);
    execute(0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0);
    chk("first_addr", i_address, 16'h0001);
    chk("first_cnt", num_inst, 1);
    for (int i = 0; i < 24; i++)
      begin
        fetch(16'($urandom), $urandom_range(0, 3));
        execute($urandom_range(0, 2) == 0, 1'($urandom), $urandom_range(0, 3) == 0,
                $urandom_range(0, 4) == 0, 16'($urandom), 16'($urandom), 0,
                $urandom_range(0, 2), 1'($urandom));
      end
    jump_to(16'h0010);
    fetch(16'hA0FC, 1);
    execute(1, 1, 0, 0, 16'hFFFC, 16'h0, 0, 0, 0);
    chk("br_taken", i_address, 16'h000D);
    jump_to(16'h0010);
    fetch(16'hA0FC, 0);
    execute(1, 0, 0, 0, 16'hFFFC, 16'h0, 0, 0, 0);
    chk("br_not_taken", i_address, 16'h0011);
    jump_to(16'h4005);
    fetch(16'h9123, 0);
    chk("jal_link", pc_value, 16'h4006);
    execute(1, 1, 1, 0, 16'h0007, 16'h0, 0, 0, 0);
    chk("jal_target", i_address, 16'h4123);
    fetch(16'hF019, 2);
    execute(0, 0, 1, 1, 16'h0, 16'h0200, 0, 0, 0);
    chk("jalr_target", i_address, 16'h0200);
    fetch(16'h1234, 0);
    execute(0, 0, 0, 0, 16'h0, 16'h0, 0, 3, 1);
    chk("stall_addr", i_address, 16'h0201);
    jump_to(16'hFFFF);
    fetch(16'h2222, 0);
    execute(0, 0, 0, 0, 16'h0, 16'h0, 0, 1, 1);
    chk("pc_wrap", i_address, 16'h0000);
    // assert reset mid-fetch with a strobe pending; it must be discarded
    i_data = 16'hBEEF;
    inputReady = 1;
    #3 reset_n = 0;
    #1;
    chk("mid_rst_readM", readM, 0);
    chk("mid_rst_addr", i_address, 16'h0000);
    chk("mid_rst_cnt", num_inst, 0);
    chk("mid_rst_instr", instruction, 16'h0000);
    tick;
    #2 reset_n = 1;
    tick;
    chk("post_rst_valid", instr_valid, 0);
    chk("post_rst_instr", instruction, 16'h0000);
    chk("post_rst_readM", readM, 1);
    inputReady = 0;
    m_pc = 16'h0000; m_cnt = 0; m_instr = 16'h0000;
    fetch(16'h6001, 0);
    execute(0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0);
    fetch(16'hF01C, 1);
    execute(0, 0, 0, 0, 16'h0, 16'h0, 1, 1, 0);
    chk("halt_valid", instr_valid, 0);
    for (int k = 0; k < 20; k++) begin
      inputReady = 1'($urandom);
      i_data = 16'($urandom);
      tick;
      chk("halt_readM", readM, 0);
      chk("halt_state", is_halted, 1);
      chk("halt_cnt", num_inst, m_cnt);
      chk("halt_instr", instruction, m_instr);
    end
    inputReady = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
